cpu_datamem_arb_mem: RTL

//  Parametrised dual-requester byte-addressable data memory for the CPU/accelerator subsystem.

---
 rtl/cpu_datamem_arb_mem_if.sv | 48 ++++
 rtl/cpu_datamem_arb_mem.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_datamem_arb_mem_if.sv
// Bus bundle for the shared data memory: CPU and accelerator request ports
// plus the clear-in-progress status flag.
interface cpu_datamem_arb_mem_if #(
  parameter int ADDR_W       = 16,
  parameter int WR_BYTES     = 4,
  parameter int CPU_RD_BYTES = 4,
  parameter int ACC_RD_BYTES = 64
);
  logic                        init_busy;

  logic                        cpu_req;
  logic                        cpu_we;
  logic [ADDR_W-1:0]           cpu_addr;
  logic [8*WR_BYTES-1:0]       cpu_wdata;
  logic [WR_BYTES-1:0]         cpu_be;
  logic                        cpu_gnt;
  logic                        cpu_rvalid;
  logic [8*CPU_RD_BYTES-1:0]   cpu_rdata;
  logic                        cpu_err;

  logic                        acc_req;
  logic                        acc_we;
  logic [ADDR_W-1:0]           acc_addr;
  logic [8*WR_BYTES-1:0]       acc_wdata;
  logic [WR_BYTES-1:0]         acc_be;
  logic                        acc_gnt;
  logic                        acc_rvalid;
  logic [8*ACC_RD_BYTES-1:0]   acc_rdata;
  logic                        acc_err;

  // Requester side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output acc_req, acc_we, acc_addr, acc_wdata, acc_be,
    input  init_busy,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  acc_gnt, acc_rvalid, acc_rdata, acc_err
  );

  // Memory side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  acc_req, acc_we, acc_addr, acc_wdata, acc_be,
    output init_busy,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output acc_gnt, acc_rvalid, acc_rdata, acc_err
  );
endinterface

// File: rtl/cpu_datamem_arb_mem.sv
// Dual-requester byte-addressable data memory. CPU and accelerator share one
// internal port through a round-robin arbiter; the whole array is zeroed in
// CLR_BYTES blocks after every reset before any request is accepted.
module cpu_datamem_arb_mem #(
  parameter int ADDR_W       = 16,
  parameter int WR_BYTES     = 4,
  parameter int CPU_RD_BYTES = 4,
  parameter int ACC_RD_BYTES = 64,
  parameter int CLR_BYTES    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_datamem_arb_mem_if.slave bus
);

  localparam int                MEM_BYTES = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(MEM_BYTES - CLR_BYTES);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           clr_ptr_q;
  // Set when the accelerator should win the next contention.
  logic                        rr_acc_q;

  logic [7:0]                  mem [MEM_BYTES];

  logic                        cpu_gnt_c, acc_gnt_c;
  logic                        cpu_oob, acc_oob;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [8*WR_BYTES-1:0]       wr_wdata;
  logic [WR_BYTES-1:0]         wr_be;
  logic [8*CPU_RD_BYTES-1:0]   cpu_rd_word;
  logic [8*ACC_RD_BYTES-1:0]   acc_rd_word;

  logic                        cpu_vld_p1, cpu_err_p1;
  logic [8*CPU_RD_BYTES-1:0]   cpu_rdata_p1;
  logic                        acc_vld_p1, acc_err_p1;
  logic [8*ACC_RD_BYTES-1:0]   acc_rdata_p1;

  // True when an access of 'size' bytes at 'addr' would run past the top of
  // memory; the sum is taken one bit wider so it never wraps.
  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr, input int size);
    logic [ADDR_W:0] end_excl;
    end_excl = {1'b0, addr} + (ADDR_W+1)'(size);
    return end_excl > (ADDR_W+1)'(MEM_BYTES);
  endfunction

  assign cpu_oob = out_of_range(bus.cpu_addr, bus.cpu_we ? WR_BYTES : CPU_RD_BYTES);
  assign acc_oob = out_of_range(bus.acc_addr, bus.acc_we ? WR_BYTES : ACC_RD_BYTES);

  // Next-state and arbitration: no grants while clearing, one grant per cycle in RUN.
  always_comb begin
    state_d   = state_q;
    cpu_gnt_c = 1'b0;
    acc_gnt_c = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (clr_ptr_q == CLR_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.cpu_req && bus.acc_req) begin
          cpu_gnt_c = !rr_acc_q;
          acc_gnt_c = rr_acc_q;
        end else begin
          cpu_gnt_c = bus.cpu_req;
          acc_gnt_c = bus.acc_req;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.cpu_gnt   = cpu_gnt_c;
  assign bus.acc_gnt   = acc_gnt_c;
  assign bus.init_busy = (state_q == ST_INIT);

  // Steer the granted requester onto the single write port; out-of-range
  // writes are accepted but never reach the array.
  assign wr_en    = cpu_gnt_c ? (bus.cpu_we && !cpu_oob) : (acc_gnt_c && bus.acc_we && !acc_oob);
  assign wr_addr  = cpu_gnt_c ? bus.cpu_addr  : bus.acc_addr;
  assign wr_wdata = cpu_gnt_c ? bus.cpu_wdata : bus.acc_wdata;
  assign wr_be    = cpu_gnt_c ? bus.cpu_be    : bus.acc_be;

  // State, clear pointer and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
      rr_acc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) clr_ptr_q <= clr_ptr_q + ADDR_W'(CLR_BYTES);
      if (cpu_gnt_c)      rr_acc_q <= 1'b1;
      else if (acc_gnt_c) rr_acc_q <= 1'b0;
    end
  end

  // Array writes: block clear during INIT, byte-enabled writes in RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      for (int i = 0; i < CLR_BYTES; i++) mem[clr_ptr_q + ADDR_W'(i)] <= 8'h00;
    end else if (wr_en) begin
      for (int i = 0; i < WR_BYTES; i++)
        if (wr_be[i]) mem[wr_addr + ADDR_W'(i)] <= wr_wdata[8*i +: 8];
    end
  end

  // Little-endian read gather for each requester's read width.
  always_comb begin
    cpu_rd_word = '0;
    acc_rd_word = '0;
    for (int i = 0; i < CPU_RD_BYTES; i++) cpu_rd_word[8*i +: 8] = mem[bus.cpu_addr + ADDR_W'(i)];
    for (int i = 0; i < ACC_RD_BYTES; i++) acc_rd_word[8*i +: 8] = mem[bus.acc_addr + ADDR_W'(i)];
  end

  // Response stage: rvalid/err one cycle after grant; rdata holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_vld_p1   <= 1'b0;
      cpu_err_p1   <= 1'b0;
      cpu_rdata_p1 <= '0;
      acc_vld_p1   <= 1'b0;
      acc_err_p1   <= 1'b0;
      acc_rdata_p1 <= '0;
    end else begin
      cpu_vld_p1 <= cpu_gnt_c && !bus.cpu_we;
      cpu_err_p1 <= cpu_gnt_c && cpu_oob;
      acc_vld_p1 <= acc_gnt_c && !bus.acc_we;
      acc_err_p1 <= acc_gnt_c && acc_oob;
      if (cpu_gnt_c && !bus.cpu_we) cpu_rdata_p1 <= cpu_oob ? '0 : cpu_rd_word;
      if (acc_gnt_c && !bus.acc_we) acc_rdata_p1 <= acc_oob ? '0 : acc_rd_word;
    end
  end

  assign bus.cpu_rvalid = cpu_vld_p1;
  assign bus.cpu_err    = cpu_err_p1;
  assign bus.cpu_rdata  = cpu_rdata_p1;
  assign bus.acc_rvalid = acc_vld_p1;
  assign bus.acc_err    = acc_err_p1;
  assign bus.acc_rdata  = acc_rdata_p1;

endmodule
